// File: rtl/parking_gate_controller_if.sv
// Request, sensor and status signals of the parking gate controller.
// master drives the requests and occupancy count; slave is the controller.
interface parking_gate_controller_if;
    logic [2:0] qtd;
    logic       entry_req;
    logic       exit_req;
    logic       car_passed;
    logic       gate_open;
    logic       full;
    logic [2:0] free;
    logic       denied;
    logic       timeout;
    logic [7:0] entries;
    logic [7:0] exits;

    modport master (
        output qtd, entry_req, exit_req, car_passed,
        input  gate_open, full, free, denied, timeout, entries, exits
    );

    modport slave (
        input  qtd, entry_req, exit_req, car_passed,
        output gate_open, full, free, denied, timeout, entries, exits
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Barrier gate controller: request edge detection, open/close timing FSM and lot status.
// Define GATE_STATS_EN to build the saturating completed-entry/exit counters.
module parking_gate_controller #(
    parameter int CAPACITY     = 4,
    parameter int OPEN_CYCLES  = 100,
    parameter int CLOSE_CYCLES = 20,
    parameter int TIMER_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parking_gate_controller_if.slave gif
);
    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSING} state_t;

    localparam logic [2:0]         CAP3       = 3'(CAPACITY);
    localparam logic [TIMER_W-1:0] OPEN_LAST  = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CLOSE_LAST = TIMER_W'(CLOSE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         qtd_q;
    logic               entry_prev_q, exit_prev_q;
    logic               gate_open_q, gate_open_d;
    logic               denied_q, denied_d;
    logic               timeout_q, timeout_d;
    logic               entry_edge, exit_edge, full;

    assign entry_edge = gif.entry_req & ~entry_prev_q;
    assign exit_edge  = gif.exit_req  & ~exit_prev_q;
    assign full       = (qtd_q >= CAP3);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TIMER_W'(1);
        denied_d  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                // Exit has priority; a simultaneous entry edge is simply dropped.
                if (exit_edge) begin
                    state_d = OPEN_OUT;
                end else if (entry_edge) begin
                    if (full) denied_d = 1'b1;
                    else      state_d  = OPEN_IN;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (gif.car_passed) begin
                    state_d = CLOSING;
                    timer_d = '0;
                end else if (timer_q == OPEN_LAST) begin
                    state_d   = CLOSING;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                if (timer_q == CLOSE_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
        endcase
        gate_open_d = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            qtd_q        <= '0;
            entry_prev_q <= 1'b0;
            exit_prev_q  <= 1'b0;
            gate_open_q  <= 1'b0;
            denied_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            qtd_q        <= gif.qtd;
            entry_prev_q <= gif.entry_req;
            exit_prev_q  <= gif.exit_req;
            gate_open_q  <= gate_open_d;
            denied_q     <= denied_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gif.gate_open = gate_open_q;
    assign gif.full      = full;
    assign gif.free      = full ? 3'd0 : (CAP3 - qtd_q);
    assign gif.denied    = denied_q;
    assign gif.timeout   = timeout_q;

`ifdef GATE_STATS_EN
    logic [7:0] entries_q, entries_d;
    logic [7:0] exits_q, exits_d;

    // Only a pass-triggered close counts; a timeout close never does.
    always_comb begin
        entries_d = entries_q;
        exits_d   = exits_q;
        if (gif.car_passed && state_q == OPEN_IN && entries_q != 8'hFF)
            entries_d = entries_q + 8'd1;
        if (gif.car_passed && state_q == OPEN_OUT && exits_q != 8'hFF)
            exits_d = exits_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            exits_q   <= '0;
        end else begin
            entries_q <= entries_d;
            exits_q   <= exits_d;
        end
    end

    assign gif.entries = entries_q;
    assign gif.exits   = exits_q;
`else
    assign gif.entries = 8'd0;
    assign gif.exits   = 8'd0;
`endif
endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller; counter expectations follow GATE_STATS_EN.
module tb_parking_gate_controller;
`ifdef GATE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    parking_gate_controller_if gif ();

    parking_gate_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gif   (gif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        int hi;
        int reopen;
        int to_cnt;
        int den_cnt;

        gif.qtd        = 3'd3;
        gif.entry_req  = 1'b0;
        gif.exit_req   = 1'b0;
        gif.car_passed = 1'b0;

        // Reset with Qtd=3
        #2;
        chk("rst_gate_open", 32'(gif.gate_open), 0);
        repeat (2) tick();
        chk("rst_full", 32'(gif.full), 0);
        chk("rst_free", 32'(gif.free), 4);
        chk("rst_denied", 32'(gif.denied), 0);
        chk("rst_timeout", 32'(gif.timeout), 0);
        chk("rst_entries", 32'(gif.entries), 0);
        chk("rst_exits", 32'(gif.exits), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_full", 32'(gif.full), 0);
        chk("post_rst_free", 32'(gif.free), 1);

        // Entry with a car passing on open cycle 5
        gif.qtd = 3'd2;
        tick();
        chk("q2_free", 32'(gif.free), 2);
        gif.entry_req = 1'b1;
        tick();
        chk("entry_open", 32'(gif.gate_open), 1);
        hi = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) gif.car_passed = 1'b1;
            tick();
            if (gif.gate_open) hi++;
        end
        gif.car_passed = 1'b0;
        chk("pass_open_cycles", 32'(hi), 5);
        chk("pass_gate_closed", 32'(gif.gate_open), 0);
        chk("pass_entries", 32'(gif.entries), 32'(STATS));
        chk("pass_no_timeout", 32'(gif.timeout), 0);
        reopen = 0;
        for (int i = 0; i < 19; i++) begin
            if (i == 4) gif.entry_req = 1'b0;
            tick();
            if (gif.gate_open) reopen++;
        end
        chk("closing_no_reopen", 32'(reopen), 0);
        // Edge on the last CLOSING cycle is dropped, the first IDLE cycle accepts
        gif.exit_req = 1'b1;
        tick();
        chk("last_closing_ignored", 32'(gif.gate_open), 0);
        gif.exit_req  = 1'b0;
        gif.entry_req = 1'b1;
        tick();
        chk("first_idle_accepted", 32'(gif.gate_open), 1);

        // No car: timeout after exactly OPEN_CYCLES
        gif.entry_req = 1'b0;
        hi = 1;
        to_cnt = 0;
        for (int i = 0; i < 105; i++) begin
            tick();
            if (gif.gate_open) hi++;
            if (gif.timeout) to_cnt++;
        end
        chk("timeout_open_cycles", 32'(hi), 100);
        chk("timeout_pulses", 32'(to_cnt), 1);
        chk("timeout_entries", 32'(gif.entries), 32'(STATS));

        // Full lot: entry denied, exit still opens
        gif.qtd = 3'd4;
        repeat (20) tick();
        chk("full_flag", 32'(gif.full), 1);
        chk("full_free", 32'(gif.free), 0);
        gif.entry_req = 1'b1;
        tick();
        chk("denied_pulse", 32'(gif.denied), 1);
        chk("denied_gate", 32'(gif.gate_open), 0);
        tick();
        chk("denied_one_cycle", 32'(gif.denied), 0);
        gif.entry_req = 1'b0;
        gif.exit_req  = 1'b1;
        tick();
        chk("exit_opens_full", 32'(gif.gate_open), 1);
        gif.exit_req   = 1'b0;
        gif.car_passed = 1'b1;
        tick();
        gif.car_passed = 1'b0;
        chk("exit_pass_closed", 32'(gif.gate_open), 0);
        chk("exit_pass_exits", 32'(gif.exits), 32'(STATS));
        chk("exit_pass_entries", 32'(gif.entries), 32'(STATS));
        gif.qtd = 3'd7;
        repeat (21) tick();
        chk("over_cap_full", 32'(gif.full), 1);
        chk("over_cap_free", 32'(gif.free), 0);

        // Simultaneous entry and exit while full: exit wins, no Denied
        gif.qtd       = 3'd4;
        tick();
        gif.entry_req = 1'b1;
        gif.exit_req  = 1'b1;
        tick();
        chk("simul_gate", 32'(gif.gate_open), 1);
        chk("simul_no_denied", 32'(gif.denied), 0);
        gif.entry_req  = 1'b0;
        gif.exit_req   = 1'b0;
        gif.car_passed = 1'b1;
        tick();
        gif.car_passed = 1'b0;
        chk("simul_exits", 32'(gif.exits), 32'(2 * STATS));
        chk("simul_entries", 32'(gif.entries), 32'(STATS));
        gif.qtd = 3'd1;
        tick();
        gif.entry_req = 1'b1;
        reopen = 0;
        den_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 2) gif.entry_req = 1'b0;
            tick();
            if (gif.gate_open) reopen++;
            if (gif.denied) den_cnt++;
        end
        chk("closing_entry_ignored", 32'(reopen), 0);
        chk("simul_denied_total", 32'(den_cnt), 0);

        // Reset on open cycle 30
        gif.qtd = 3'd0;
        tick();
        gif.entry_req = 1'b1;
        tick();
        repeat (29) tick();
        chk("pre_reset_open", 32'(gif.gate_open), 1);
        gif.entry_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_gate", 32'(gif.gate_open), 0);
        chk("async_reset_entries", 32'(gif.entries), 0);
        chk("async_reset_exits", 32'(gif.exits), 0);
        chk("async_reset_free", 32'(gif.free), 4);
        tick();
        rst_n = 1'b1;
        tick();
        gif.entry_req = 1'b1;
        tick();
        chk("reopen_after_reset", 32'(gif.gate_open), 1);
        gif.entry_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
